// File: rtl/i2s_pkg.sv
// Shared types and default sizes for the I2S microphone receiver.
package i2s_pkg;

  localparam int I2S_DATA_W = 24;
  localparam int I2S_SLOT_W = 32;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_t;

  typedef struct packed {
    logic [I2S_DATA_W-1:0] left;
    logic [I2S_DATA_W-1:0] right;
  } stereo_pair_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd = rd_en && !empty;
  // A write into a full FIFO succeeds when the same cycle frees a slot.
  assign do_wr = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S stereo microphone receiver: oversampled pins, word deserialiser, pair FIFO.
module i2s_mic_rx
  import i2s_pkg::*;
#(
  parameter int DATA_W     = I2S_DATA_W,
  parameter int SLOT_W     = I2S_SLOT_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sck,
  input  logic              ws,
  input  logic              sd,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  input  logic              ovr_clear,
  output logic              frame_err,
  output i2s_state_t        dbg_state
);
  localparam int CW = $clog2(SLOT_W + 1);
  localparam logic [CW-1:0] DATA_CNT = CW'(DATA_W);
  localparam logic [CW-1:0] SLOT_CNT = CW'(SLOT_W);

  logic sck_s1_q, sck_s2_q, sck_prev_q;
  logic ws_s1_q, ws_s2_q, sd_s1_q, sd_s2_q;

  i2s_state_t          state_q, state_d;
  logic                ws_last_q, ws_last_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                bad_q, bad_d;
  logic [DATA_W-1:0]   left_sr_q, left_sr_d, right_sr_q, right_sr_d;
  logic                push_q, push_d;
  logic [2*DATA_W-1:0] pair_q, pair_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;

  logic                sck_rise, delay_slot, short_word;
  logic                fifo_full, fifo_empty;
  logic [2*DATA_W-1:0] head;

  assign sck_rise   = sck_s2_q && !sck_prev_q;
  assign delay_slot = (ws_s2_q != ws_last_q);
  assign short_word = (cnt_q < DATA_CNT);

  always_comb begin
    state_d     = state_q;
    ws_last_d   = ws_last_q;
    cnt_d       = cnt_q;
    bad_d       = bad_q;
    left_sr_d   = left_sr_q;
    right_sr_d  = right_sr_q;
    push_d      = 1'b0;
    pair_d      = pair_q;
    frame_err_d = 1'b0;
    if (sck_rise) begin
      ws_last_d = ws_s2_q;
      if (delay_slot) begin
        // The bit in a delay slot belongs to the previous word and is dropped.
        cnt_d = '0;
        case (state_q)
          HUNT: if (!ws_s2_q) begin
            state_d = LEFT;
            bad_d   = 1'b0;
          end
          LEFT: if (ws_s2_q) begin
            state_d = RIGHT;
            if (short_word) begin
              frame_err_d = 1'b1;
              bad_d       = 1'b1;
            end
          end
          RIGHT: if (!ws_s2_q) begin
            state_d = LEFT;
            bad_d   = 1'b0;
            if (short_word) begin
              frame_err_d = 1'b1;
            end else if (!bad_q) begin
              push_d = 1'b1;
              pair_d = {left_sr_q, right_sr_q};
            end
          end
          default: state_d = HUNT;
        endcase
      end else begin
        if (short_word && state_q == LEFT)  left_sr_d  = {left_sr_q[DATA_W-2:0], sd_s2_q};
        if (short_word && state_q == RIGHT) right_sr_d = {right_sr_q[DATA_W-2:0], sd_s2_q};
        if (cnt_q != SLOT_CNT) cnt_d = cnt_q + 1'b1;
      end
    end
    // ws_last keeps tracking while disabled so re-enabling aligns on the next left word.
    if (!enable) begin
      state_d     = HUNT;
      cnt_d       = '0;
      bad_d       = 1'b0;
      left_sr_d   = '0;
      right_sr_d  = '0;
      push_d      = 1'b0;
      frame_err_d = 1'b0;
    end
  end

  // Overrun only when a push meets a full FIFO that is not popped in the same cycle.
  always_comb begin
    overrun_d = overrun_q;
    if (ovr_clear) overrun_d = 1'b0;
    if (push_q && fifo_full && !out_ready) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_s1_q    <= 1'b0;
      sck_s2_q    <= 1'b0;
      sck_prev_q  <= 1'b0;
      ws_s1_q     <= 1'b0;
      ws_s2_q     <= 1'b0;
      sd_s1_q     <= 1'b0;
      sd_s2_q     <= 1'b0;
      state_q     <= HUNT;
      ws_last_q   <= 1'b0;
      cnt_q       <= '0;
      bad_q       <= 1'b0;
      left_sr_q   <= '0;
      right_sr_q  <= '0;
      push_q      <= 1'b0;
      pair_q      <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sck_s1_q    <= sck;
      sck_s2_q    <= sck_s1_q;
      sck_prev_q  <= sck_s2_q;
      ws_s1_q     <= ws;
      ws_s2_q     <= ws_s1_q;
      sd_s1_q     <= sd;
      sd_s2_q     <= sd_s1_q;
      state_q     <= state_d;
      ws_last_q   <= ws_last_d;
      cnt_q       <= cnt_d;
      bad_q       <= bad_d;
      left_sr_q   <= left_sr_d;
      right_sr_q  <= right_sr_d;
      push_q      <= push_d;
      pair_q      <= pair_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  sync_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_q),
    .wr_data (pair_q),
    .rd_en   (out_ready),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign left_data  = head[2*DATA_W-1:DATA_W];
  assign right_data = head[DATA_W-1:0];
  assign out_valid  = !fifo_empty;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Directed bench: an I2S master at clk/16 with 32-bit slots feeding i2s_mic_rx.
module tb_i2s_mic_rx;
  import i2s_pkg::*;

  logic        clk = 1'b0;
  logic        reset, enable, sck, ws, sd, out_ready, ovr_clear;
  logic [23:0] left_data, right_data;
  logic        out_valid, overrun, frame_err;
  i2s_state_t  dbg_state;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  logic drv_ws = 1'b0;

  always #10 clk = ~clk;

  i2s_mic_rx dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .sck        (sck),
    .ws         (ws),
    .sd         (sd),
    .left_data  (left_data),
    .right_data (right_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .ovr_clear  (ovr_clear),
    .frame_err  (frame_err),
    .dbg_state  (dbg_state)
  );

  always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One SCK period; ws/sd change while SCK is low.
  task automatic sck_cycle(input logic w, input logic d);
    ws = w;
    sd = d;
    repeat (8) @(negedge clk);
    sck = 1'b1;
    repeat (8) @(negedge clk);
    sck = 1'b0;
  endtask

  // n slots of one word; the delay slot is emitted only when ws actually changes.
  task automatic send_word(input logic w, input logic [23:0] d, input int n);
    for (int i = (w == drv_ws) ? 1 : 0; i < n; i++) begin
      sck_cycle(w, (i >= 1 && i <= 24) ? d[24 - i] : 1'b0);
    end
    drv_ws = w;
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
    send_word(1'b0, l, 32);
    send_word(1'b1, r, 32);
    sck_cycle(1'b0, 1'b0);
    drv_ws = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " valid"}, 48'(out_valid), 48'd1);
  endtask

  task automatic pop_expect(input string tag, input logic [23:0] l, input logic [23:0] r);
    stereo_pair_t exp_pair;
    exp_pair.left  = l;
    exp_pair.right = r;
    wait_valid(tag);
    check({tag, " pair"}, {left_data, right_data}, exp_pair);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; sck = 1'b0; ws = 1'b0; sd = 1'b0;
    out_ready = 1'b0; ovr_clear = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset outputs", {left_data, right_data}, 48'd0);
    check("reset valid", 48'(out_valid), 48'd0);
    check("reset overrun", 48'(overrun), 48'd0);
    check("reset state", 48'(dbg_state), 48'(HUNT));

    // Single frame after a right-channel preamble.
    send_word(1'b1, 24'd0, 2);
    send_frame(24'h123456, 24'hABCDEF);
    pop_expect("single", 24'h123456, 24'hABCDEF);
    check("single empty", 48'(out_valid), 48'd0);
    check("single frame_err", 48'(fe_cnt), 48'd0);
    check("single overrun", 48'(overrun), 48'd0);

    // Reset during a right word flushes the FIFO and discards the partial frame.
    send_frame(24'h111111, 24'h222222);
    send_word(1'b0, 24'h777777, 32);
    send_word(1'b1, 24'h888888, 10);
    check("pre-reset valid", 48'(out_valid), 48'd1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("flush valid", 48'(out_valid), 48'd0);
    send_word(1'b1, 24'h888888, 22);
    check("midframe hunt", 48'(dbg_state), 48'(HUNT));
    check("midframe no pair", 48'(out_valid), 48'd0);
    send_frame(24'h0ABCDE, 24'h654321);
    pop_expect("midframe", 24'h0ABCDE, 24'h654321);

    // Backpressure: five pairs into a four-deep FIFO.
    for (int k = 1; k <= 5; k++) send_frame(24'(k), 24'(k));
    check("bp overrun", 48'(overrun), 48'd1);
    for (int k = 1; k <= 4; k++) pop_expect("bp drain", 24'(k), 24'(k));
    check("bp empty", 48'(out_valid), 48'd0);
    ovr_clear = 1'b1;
    @(negedge clk);
    ovr_clear = 1'b0;
    @(negedge clk);
    check("bp ovr_clear", 48'(overrun), 48'd0);

    // Short right word is flagged and never pushed.
    send_word(1'b0, 24'hAAAAAA, 32);
    send_word(1'b1, 24'h555555, 17);
    send_frame(24'h0F0F0F, 24'hF0F0F0);
    check("short frame_err", 48'(fe_cnt), 48'd1);
    pop_expect("short next", 24'h0F0F0F, 24'hF0F0F0);
    check("short empty", 48'(out_valid), 48'd0);

    // Fill to four, then push with a pop in the same cycle.
    for (int k = 6; k <= 9; k++) send_frame(24'(k), 24'(k));
    send_word(1'b0, 24'd10, 32);
    send_word(1'b1, 24'd10, 32);
    ws = 1'b0; sd = 1'b0; drv_ws = 1'b0;
    repeat (8) @(negedge clk);
    sck = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (4) @(negedge clk);
    sck = 1'b0;
    @(negedge clk);
    check("pushpop overrun", 48'(overrun), 48'd0);
    for (int k = 7; k <= 10; k++) pop_expect("pushpop drain", 24'(k), 24'(k));
    check("pushpop empty", 48'(out_valid), 48'd0);

    // Enable dropped mid right word: the interrupted frame never appears.
    send_word(1'b0, 24'h333333, 32);
    send_word(1'b1, 24'h999999, 10);
    enable = 1'b0;
    send_word(1'b1, 24'h999999, 22);
    check("disabled hunt", 48'(dbg_state), 48'(HUNT));
    check("disabled no pair", 48'(out_valid), 48'd0);
    enable = 1'b1;
    send_frame(24'h444444, 24'h555555);
    pop_expect("reenable", 24'h444444, 24'h555555);
    check("reenable empty", 48'(out_valid), 48'd0);
    check("final frame_err", 48'(fe_cnt), 48'd1);
    check("final overrun", 48'(overrun), 48'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_mic_rx.md
# i2s_mic_rx

Receiver for the I2S MEMS microphone pair on GPIO_0 (SCK driven by the on-board PLL, SD and WS from the microphones). It runs entirely in the 50 MHz `clk` domain. It oversamples the three I2S pins, deserialises left/right words and queues aligned stereo pairs in a small FIFO. It sits directly downstream of the pins and upstream of the Avalon-MM audio register interface in `soc_system`, which drains pairs via a valid/ready handshake.

## Interface
- `DATA_W`, 24: bits captured per channel, MSB first.
- `SLOT_W`, 32: nominal bit slots per channel; bit counter saturates here.
- `FIFO_DEPTH`, 4: stereo pairs buffered; power of two ≥ 2.

Ports:
- `clk` in 1: system clock, 50 MHz; must be ≥ 4× SCK frequency.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: low = ignore bus, return to HUNT, FIFO contents kept.
- `sck` in 1: I2S bit clock (asynchronous to `clk`).
- `ws` in 1: word select, 0 = left, 1 = right.
- `sd` in 1: serial data.
- `left_data` out DATA_W: left sample, two's complement, head of FIFO.
- `right_data` out DATA_W: right sample, head of FIFO.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer pops on `out_valid && out_ready`.
- `overrun` out 1: sticky; a completed pair arrived with FIFO full.
- `ovr_clear` in 1: single-cycle clear of `overrun`.
- `frame_err` out 1: one-cycle pulse; a word finished with fewer than DATA_W bits.

## Operation
- `sck`, `ws`, `sd` each pass through identical 2-FF synchronisers. An SCK rising edge is detected when sync `sck` = 1 and the prior registered value = 0. `ws`/`sd` are sampled from synchronised values in that same cycle.
- On each SCK rising edge: compare sampled `ws` with `ws_last` (value at previous rising edge), then update `ws_last`.
- **Delay slot**: `ws != ws_last`. The new word begins and bit count is cleared. The bit on `sd` belongs to the previous word's slot and is not captured.
- **Data edge**: if bit count < DATA_W, shift `sd` into the current channel's shift register (first bit → MSB). The count increments and saturates at SLOT_W.
- **States**: HUNT, LEFT, RIGHT.
  - HUNT → LEFT on a delay slot with `ws` = 0. Other edges in HUNT are ignored.
  - LEFT → RIGHT on a delay slot with `ws` = 1. The left word is finalised.
  - RIGHT → LEFT on a delay slot with `ws` = 0. The right word is finalised and the pair is pushed.
- **Finalise**: if count < DATA_W, pulse `frame_err` and mark the pair bad. A bad pair is never pushed. The bad mark clears on entry to LEFT.
- **Push**: occurs only if the pair is good.
  - FIFO not full: write {left, right}.
  - FIFO full: drop the new pair and set `overrun`. Stored data is untouched.
- Bits beyond DATA_W in a slot are ignored.
- `enable` = 0 forces HUNT and clears the bad mark and shift registers. Popping continues.
- `ovr_clear` and a new overrun in the same cycle: `overrun` stays 1.

## Timing
- **Reset**: all outputs 0, state HUNT, FIFO empty, `ws_last` = 0, `overrun` = 0.
- **Reset mid-word**: the partial word is discarded and the FIFO is flushed. Capture resumes at the next `ws` 1→0 delay slot.
- **Edge recognition**: 3 `clk` after the SCK pin edge (2 sync + 1 edge register).
- **Push**: registered in the cycle after the detected RIGHT→LEFT delay-slot edge. `out_valid` = 1 the following cycle (2 `clk` after the edge cycle).
- **FIFO**: show-ahead. Data is stable while `out_valid && !out_ready`.
- **Simultaneous push and pop when full**: the pop frees a slot and the push succeeds, with no overrun.
- **Simultaneous push and pop when empty**: `out_valid` follows the push; the pop is not possible.
- **`frame_err`**: asserts in the cycle after the delay-slot edge that finalises a short word.

## Structure
- Package `i2s_pkg`:
  - `typedef enum logic [1:0] {HUNT, LEFT, RIGHT} i2s_state_t`
  - default constants for DATA_W / SLOT_W
  - `typedef struct packed` for the stereo pair
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH): show-ahead, `full`/`empty`, pointer wrap via extra MSB. It is instantiated with WIDTH = 2·DATA_W.
- The synchroniser is inline (three 2-FF chains), not a separate module.

## Test plan
Bench models a master with SCK = `clk`/16, 32-bit slots, standard I2S one-bit delay.
- **Single frame**: left 0x123456, right 0xABCDEF (padded with 8 zero bits) → one pair out with exactly those values. `frame_err` = 0, `overrun` = 0.
- **Mid-frame start**: reset released during a right word → the partial frame is ignored. The first pair out is the next full left/right pair.
- **Backpressure**: `out_ready` = 0 while 5 pairs (0x000001..0x000005 on both channels) arrive → 4 are stored and the 5th is dropped. `overrun` = 1. Draining yields 1, 2, 3, 4 in order; `ovr_clear` → `overrun` = 0.
- **Short word**: right slot truncated to 16 bits → `frame_err` pulses once and the pair is not pushed. The following full pair (0x0F0F0F/0xF0F0F0) is output.
- **Push/pop at full**: FIFO full with `out_ready` = 1 in the push cycle → no overrun, occupancy stays 4.
- **`enable` low mid-word**: no pair pushed for the interrupted frame. After `enable` returns, the first pair starts at the next left word.
